// File: rtl/cmd_decoder_pkg.sv
// Shared command-link definitions, common to the command encoder and decoder.
// Framing bytes, sink count and the decoder state encoding.
package cmd_decoder_pkg;

  localparam int         CMD_NUM_SOURCES = 4;
  localparam logic [7:0] CMD_PREFIX      = 8'hA5;
  localparam logic [7:0] CMD_ADDR_AST    = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_DEST  = 3'd2,
    ST_GET_LEN   = 3'd3,
    ST_GET_DATA  = 3'd4,
    ST_GET_CRC   = 3'd5,
    ST_SKIP_DATA = 3'd6,
    ST_SKIP_CRC  = 3'd7
  } state_t;

endpackage

// File: rtl/cmd_decoder.sv
// Byte-stream command frame decoder: PREFIX, ADDR_AST, dest, len, payload, crc.
// Payload bytes are routed to one of NUM_SOURCES sinks one clock after arrival.
module cmd_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         NUM_SOURCES    = CMD_NUM_SOURCES,
  parameter logic [7:0] PREFIX         = CMD_PREFIX,
  parameter logic [7:0] ADDR_AST       = CMD_ADDR_AST,
  localparam int        DEST_W         = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic [NUM_SOURCES-1:0] full_bus,
  output logic [NUM_SOURCES-1:0] wrreq_bus,
  output logic [7:0]             data_out,
  output logic                   frame_done,
  output logic [DEST_W-1:0]      dest_out,
  output logic                   crc_err,
  output logic                   ovf_err,
  output logic                   timeout_err,
  output logic [2:0]             my_state
);

  localparam int              CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                   state, state_nxt;
  logic [DEST_W-1:0]        dest;
  logic                     skip;
  logic [7:0]               len, cnt, crc_acc;
  logic [7:0]               cnt_inc;
  logic [CNT_W-1:0]         idle_cnt;
  logic                     timeout_hit;
  logic [NUM_SOURCES-1:0]   wr_nxt;
  logic                     done_nxt, crc_err_nxt, ovf_nxt, to_nxt;

  assign cnt_inc     = cnt + 8'd1;
  // rx_valid always wins over an expiring idle counter
  assign timeout_hit = !rx_valid && (state != ST_IDLE) && (idle_cnt == TO_LAST);
  assign dest_out    = dest;
  assign my_state    = state;

  always_comb begin
    state_nxt   = state;
    wr_nxt      = '0;
    done_nxt    = 1'b0;
    crc_err_nxt = 1'b0;
    ovf_nxt     = 1'b0;
    to_nxt      = 1'b0;
    if (rx_valid) begin
      unique case (state)
        ST_IDLE:      if (rx_data == PREFIX) state_nxt = ST_GET_ADDR;
        ST_GET_ADDR:  state_nxt = (rx_data == ADDR_AST) ? ST_GET_DEST : ST_IDLE;
        ST_GET_DEST:  state_nxt = ST_GET_LEN;
        ST_GET_LEN: begin
          if (rx_data == 8'd0) state_nxt = skip ? ST_SKIP_CRC : ST_GET_CRC;
          else                 state_nxt = skip ? ST_SKIP_DATA : ST_GET_DATA;
        end
        ST_GET_DATA: begin
          if (full_bus[dest]) ovf_nxt = 1'b1;
          else                wr_nxt[dest] = 1'b1;
          if (cnt_inc == len) state_nxt = ST_GET_CRC;
        end
        ST_GET_CRC: begin
          done_nxt    = 1'b1;
          crc_err_nxt = (rx_data != crc_acc);
          state_nxt   = ST_IDLE;
        end
        ST_SKIP_DATA: if (cnt_inc == len) state_nxt = ST_SKIP_CRC;
        ST_SKIP_CRC:  state_nxt = ST_IDLE;
        default:      state_nxt = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = ST_IDLE;
      to_nxt    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dest        <= '0;
      skip        <= 1'b0;
      len         <= '0;
      cnt         <= '0;
      crc_acc     <= '0;
      idle_cnt    <= '0;
      data_out    <= '0;
      wrreq_bus   <= '0;
      frame_done  <= 1'b0;
      crc_err     <= 1'b0;
      ovf_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Output stage: strobes and pulses land one clock after the byte
      wrreq_bus   <= wr_nxt;
      frame_done  <= done_nxt;
      crc_err     <= crc_err_nxt;
      ovf_err     <= ovf_nxt;
      timeout_err <= to_nxt;
      if (rx_valid)                 idle_cnt <= '0;
      else if (idle_cnt != TO_LAST) idle_cnt <= idle_cnt + CNT_W'(1);
      if (rx_valid) begin
        unique case (state)
          ST_GET_DEST: begin
            dest <= rx_data[DEST_W-1:0];
            skip <= (int'(rx_data) >= NUM_SOURCES);
          end
          ST_GET_LEN: begin
            len     <= rx_data;
            cnt     <= '0;
            crc_acc <= '0;
          end
          ST_GET_DATA: begin
            cnt      <= cnt_inc;
            crc_acc  <= crc_acc + rx_data;
            data_out <= rx_data;
          end
          ST_SKIP_DATA: cnt <= cnt_inc;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: directed frames plus randomized frames checked
// against a frame-level model of the expected sink writes and pulses.
module tb_cmd_decoder;
  import cmd_decoder_pkg::*;

  localparam int NS = CMD_NUM_SOURCES;
  localparam int DW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [7:0]    rx_data = 8'd0;
  logic          rx_valid = 1'b0;
  logic [NS-1:0] full_bus = '0;
  logic [NS-1:0] wrreq_bus;
  logic [7:0]    data_out;
  logic          frame_done, crc_err, ovf_err, timeout_err;
  logic [DW-1:0] dest_out;
  logic [2:0]    my_state;

  cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .full_bus(full_bus), .wrreq_bus(wrreq_bus), .data_out(data_out),
    .frame_done(frame_done), .dest_out(dest_out), .crc_err(crc_err),
    .ovf_err(ovf_err), .timeout_err(timeout_err), .my_state(my_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0] wr;
    logic [7:0]    data;
    logic          ovf;
    logic          done;
    logic          crc;
    logic          to;
    logic [2:0]    st;
  } obs_t;

  int            n_tests = 0;
  int            n_fail = 0;
  logic [7:0]    byte_q[$];
  logic [NS-1:0] full_q[$];
  obs_t          exp_q[$];
  obs_t          obs_q[$];
  logic [7:0]    wdata_q[$];
  int            agg_wr, agg_ovf, agg_done, agg_crc, agg_to;
  logic [NS-1:0] agg_wr_or;

  function automatic void clear_q();
    byte_q.delete(); full_q.delete(); exp_q.delete();
  endfunction

  function automatic void push(input logic [7:0] b, input logic [NS-1:0] f, input obs_t e);
    byte_q.push_back(b); full_q.push_back(f); exp_q.push_back(e);
  endfunction

  // Frame-level model: what each byte of a frame must cause one clock later
  function automatic void model_frame(input int dest_byte, input int len, input bit bad_crc,
                                      input int full_pct);
    int            sum = 0;
    bit            live = (dest_byte < NS);
    obs_t          e;
    logic [7:0]    b;
    logic [NS-1:0] fm;
    push(PREFIX_B(), '0, '0);
    push(CMD_ADDR_AST, '0, '0);
    push(8'(dest_byte), '0, '0);
    push(8'(len), '0, '0);
    for (int i = 0; i < len; i++) begin
      b  = 8'($urandom);
      fm = NS'($urandom);
      e  = '0;
      if (live) begin
        fm[dest_byte] = ($urandom_range(99) < full_pct);
        if (fm[dest_byte]) e.ovf = 1'b1;
        else begin
          e.wr   = NS'(1) << dest_byte;
          e.data = b;
        end
      end
      sum = (sum + int'(b)) % 256;
      push(b, fm, e);
    end
    e = '0;
    if (live) begin
      e.done = 1'b1;
      e.crc  = bad_crc;
    end
    push(bad_crc ? (8'(sum) ^ 8'($urandom_range(255, 1))) : 8'(sum), '0, e);
  endfunction

  function automatic logic [7:0] PREFIX_B();
    return CMD_PREFIX;
  endfunction

  task automatic send(input logic [7:0] b, input logic [NS-1:0] f, output obs_t o);
    rx_data = b; rx_valid = 1'b1; full_bus = f;
    @(posedge clk); @(negedge clk);
    rx_valid = 1'b0; full_bus = '0;
    o.wr = wrreq_bus; o.data = data_out; o.ovf = ovf_err; o.done = frame_done;
    o.crc = crc_err; o.to = timeout_err; o.st = my_state;
  endtask

  task automatic run_queue();
    obs_t o;
    obs_q.delete(); wdata_q.delete();
    agg_wr = 0; agg_ovf = 0; agg_done = 0; agg_crc = 0; agg_to = 0; agg_wr_or = '0;
    foreach (byte_q[i]) begin
      send(byte_q[i], full_q[i], o);
      obs_q.push_back(o);
      if (o.wr != '0) begin
        agg_wr++; agg_wr_or |= o.wr; wdata_q.push_back(o.data);
      end
      agg_ovf += int'(o.ovf); agg_done += int'(o.done);
      agg_crc += int'(o.crc); agg_to += int'(o.to);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({wrreq_bus, data_out, dest_out, frame_done, crc_err, ovf_err, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: wr=%b data=%h dest=%0d done=%b crc=%b ovf=%b to=%b, want all 0",
               wrreq_bus, data_out, dest_out, frame_done, crc_err, ovf_err, timeout_err);
    end
    n_tests++;
    if (my_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", my_state);
    end
  endtask

  task automatic basic_frame(input logic [7:0] crc);
    clear_q();
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'd1, '0, '0); push(8'd3, '0, '0);
    push(8'h10, '0, '0); push(8'h20, '0, '0); push(8'h30, '0, '0); push(crc, '0, '0);
    run_queue();
  endtask

  task automatic test_basic();
    basic_frame(8'h60);
    n_tests++;
    if (agg_wr !== 3 || agg_wr_or !== NS'(2)) begin
      n_fail++; $display("FAIL basic_writes: got %0d strobes mask %b, want 3 mask 0010", agg_wr, agg_wr_or);
    end
    n_tests++;
    if (obs_q[4].wr !== NS'(2) || obs_q[4].data !== 8'h10) begin
      n_fail++; $display("FAIL basic_latency: got wr=%b data=%h, want 0010 10", obs_q[4].wr, obs_q[4].data);
    end
    n_tests++;
    if (wdata_q.size() != 3 || wdata_q[1] !== 8'h20 || wdata_q[2] !== 8'h30) begin
      n_fail++; $display("FAIL basic_data: got %0d bytes, want 10 20 30", wdata_q.size());
    end
    n_tests++;
    if ({obs_q[7].done, obs_q[7].crc} !== 2'b10 || agg_done !== 1) begin
      n_fail++; $display("FAIL basic_done: got done=%b crc=%b count=%0d, want 1 0 1",
                         obs_q[7].done, obs_q[7].crc, agg_done);
    end
    n_tests++;
    if (dest_out !== DW'(1)) begin
      n_fail++; $display("FAIL basic_dest: got %0d want 1", dest_out);
    end
  endtask

  task automatic test_crc_err();
    basic_frame(8'h61);
    n_tests++;
    if (agg_wr !== 3) begin
      n_fail++; $display("FAIL crcerr_writes: got %0d want 3", agg_wr);
    end
    n_tests++;
    if ({obs_q[7].done, obs_q[7].crc} !== 2'b11 || agg_crc !== 1) begin
      n_fail++; $display("FAIL crcerr_pulse: got done=%b crc=%b count=%0d, want 1 1 1",
                         obs_q[7].done, obs_q[7].crc, agg_crc);
    end
  endtask

  task automatic test_overflow();
    clear_q();
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'd0, '0, '0); push(8'd2, '0, '0);
    push(8'h44, '0, '0); push(8'h55, NS'(1), '0); push(8'h99, '0, '0);
    run_queue();
    n_tests++;
    if (agg_wr !== 1 || obs_q[4].wr !== NS'(1) || obs_q[5].wr !== '0) begin
      n_fail++; $display("FAIL ovf_writes: got %0d strobes, 2nd wr=%b, want 1 and 0", agg_wr, obs_q[5].wr);
    end
    n_tests++;
    if (obs_q[5].ovf !== 1'b1 || agg_ovf !== 1) begin
      n_fail++; $display("FAIL ovf_pulse: got %b count=%0d want 1 1", obs_q[5].ovf, agg_ovf);
    end
    n_tests++;
    if ({obs_q[6].done, obs_q[6].crc} !== 2'b10) begin
      n_fail++; $display("FAIL ovf_done: got done=%b crc=%b want 1 0", obs_q[6].done, obs_q[6].crc);
    end
  endtask

  task automatic test_skip();
    clear_q();
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'(NS), '0, '0); push(8'd4, '0, '0);
    push(8'd1, '1, '0); push(8'd2, '0, '0); push(8'd3, '0, '0); push(8'd4, '0, '0); push(8'd10, '0, '0);
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'd3, '0, '0); push(8'd2, '0, '0);
    push(8'h07, '0, '0); push(8'h08, '0, '0); push(8'h0F, '0, '0);
    run_queue();
    n_tests++;
    if (agg_wr !== 2 || agg_ovf !== 0 || obs_q[13].wr !== NS'(8) || obs_q[14].data !== 8'h08) begin
      n_fail++; $display("FAIL skip_writes: got %0d strobes ovf=%0d wr13=%b d14=%h, want 2 0 1000 08",
                         agg_wr, agg_ovf, obs_q[13].wr, obs_q[14].data);
    end
    n_tests++;
    if (agg_done !== 1 || obs_q[15].done !== 1'b1 || agg_crc !== 0) begin
      n_fail++; $display("FAIL skip_done: got done count %0d last=%b crc=%0d, want 1 1 0",
                         agg_done, obs_q[15].done, agg_crc);
    end
  endtask

  task automatic test_len_zero_prefix();
    clear_q();
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'd2, '0, '0); push(8'd0, '0, '0);
    push(8'd0, '0, '0);
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'd0, '0, '0); push(8'd3, '0, '0);
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(CMD_PREFIX, '0, '0);
    push(8'(int'(CMD_PREFIX) * 2 + int'(CMD_ADDR_AST)), '0, '0);
    run_queue();
    n_tests++;
    if (obs_q[4].done !== 1'b1 || obs_q[4].crc !== 1'b0) begin
      n_fail++; $display("FAIL len0_done: got done=%b crc=%b want 1 0", obs_q[4].done, obs_q[4].crc);
    end
    n_tests++;
    if (agg_wr !== 3 || wdata_q.size() != 3 || wdata_q[0] !== CMD_PREFIX || wdata_q[1] !== CMD_ADDR_AST) begin
      n_fail++; $display("FAIL prefix_payload: got %0d writes, want 3 with prefix data", agg_wr);
    end
    n_tests++;
    if (agg_done !== 2 || agg_crc !== 0) begin
      n_fail++; $display("FAIL prefix_done: got done=%0d crc=%0d want 2 0", agg_done, agg_crc);
    end
  endtask

  task automatic test_timeout();
    clear_q();
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'd1, '0, '0); push(8'd4, '0, '0);
    push(8'h11, '0, '0);
    run_queue();
    n_tests++;
    if (agg_wr !== 1) begin
      n_fail++; $display("FAIL to_first_write: got %0d want 1", agg_wr);
    end
    for (int i = 1; i <= TO + 4; i++) begin
      @(posedge clk); @(negedge clk);
      n_tests++;
      if (timeout_err !== (i == TO)) begin
        n_fail++; $display("FAIL to_pulse_c%0d: got %b want %b", i, timeout_err, (i == TO));
      end
    end
    n_tests++;
    if (my_state !== ST_IDLE) begin
      n_fail++; $display("FAIL to_state: got %0d want 0", my_state);
    end
    basic_frame(8'h60);
    n_tests++;
    if (agg_wr !== 3 || agg_done !== 1 || agg_crc !== 0) begin
      n_fail++; $display("FAIL to_next_frame: got wr=%0d done=%0d crc=%0d want 3 1 0", agg_wr, agg_done, agg_crc);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    push(CMD_PREFIX, '0, '0); push(CMD_ADDR_AST, '0, '0); push(8'd2, '0, '0); push(8'd3, '0, '0);
    run_queue();
    n_rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_rst = 1'b1;
    n_tests++;
    if ({wrreq_bus, data_out, dest_out, frame_done, crc_err, ovf_err, timeout_err} !== '0) begin
      n_fail++; $display("FAIL midreset_outputs: wr=%b data=%h dest=%0d done=%b errs=%b%b%b, want all 0",
                         wrreq_bus, data_out, dest_out, frame_done, crc_err, ovf_err, timeout_err);
    end
    n_tests++;
    if (my_state !== ST_IDLE) begin
      n_fail++; $display("FAIL midreset_state: got %0d want 0", my_state);
    end
    clear_q();
    push(8'h01, '0, '0); push(8'h02, '0, '0); push(8'h03, '0, '0); push(8'h06, '0, '0);
    run_queue();
    n_tests++;
    if (agg_wr !== 0 || agg_done !== 0 || agg_crc !== 0) begin
      n_fail++; $display("FAIL midreset_tail: got wr=%0d done=%0d crc=%0d want 0 0 0", agg_wr, agg_done, agg_crc);
    end
  endtask

  task automatic test_back_to_back();
    clear_q();
    for (int f = 0; f < 3; f++) model_frame(int'($urandom_range(NS - 1)), int'($urandom_range(5, 1)), f == 1, 25);
    run_queue();
    foreach (exp_q[i]) begin
      n_tests++;
      if (obs_q[i].wr !== exp_q[i].wr || (exp_q[i].wr != '0 && obs_q[i].data !== exp_q[i].data) ||
          obs_q[i].ovf !== exp_q[i].ovf || obs_q[i].done !== exp_q[i].done ||
          obs_q[i].crc !== exp_q[i].crc || obs_q[i].to !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_byte%0d: got wr=%b d=%h ovf=%b done=%b crc=%b to=%b want wr=%b d=%h ovf=%b done=%b crc=%b to=0",
                 i, obs_q[i].wr, obs_q[i].data, obs_q[i].ovf, obs_q[i].done, obs_q[i].crc, obs_q[i].to,
                 exp_q[i].wr, exp_q[i].data, exp_q[i].ovf, exp_q[i].done, exp_q[i].crc);
      end
    end
  endtask

  task automatic test_random();
    obs_t       o;
    logic [7:0] b;
    int         d;
    for (int f = 0; f < 40; f++) begin
      clear_q();
      for (int n = int'($urandom_range(2)); n > 0; n--) begin
        b = 8'($urandom);
        if (b == CMD_PREFIX) b = b + 8'd1;
        push(b, '0, '0);
      end
      if ($urandom_range(3) == 0) begin
        b = 8'($urandom);
        if (b == CMD_ADDR_AST) b = b ^ 8'h01;
        push(CMD_PREFIX, '0, '0); push(b, '0, '0);
      end
      d = ($urandom_range(7) == 0) ? 255 : int'($urandom_range(NS + 1));
      model_frame(d, int'($urandom_range(6)), $urandom_range(2) == 0, 25);
      foreach (byte_q[i]) begin
        repeat ($urandom_range(3)) begin @(posedge clk); @(negedge clk); end
        send(byte_q[i], full_q[i], o);
        n_tests++;
        if (o.wr !== exp_q[i].wr || (exp_q[i].wr != '0 && o.data !== exp_q[i].data) ||
            o.ovf !== exp_q[i].ovf || o.done !== exp_q[i].done || o.crc !== exp_q[i].crc || o.to !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_f%0d_b%0d: got wr=%b d=%h ovf=%b done=%b crc=%b to=%b want wr=%b d=%h ovf=%b done=%b crc=%b to=0",
                   f, i, o.wr, o.data, o.ovf, o.done, o.crc, o.to,
                   exp_q[i].wr, exp_q[i].data, exp_q[i].ovf, exp_q[i].done, exp_q[i].crc);
        end
      end
      n_tests++;
      if (my_state !== ST_IDLE || (d < NS && dest_out !== DW'(d))) begin
        n_fail++; $display("FAIL rand_f%0d_end: got state=%0d dest=%0d want 0 %0d", f, my_state, dest_out, d);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    test_reset();
    n_rst = 1'b1;
    @(posedge clk); @(negedge clk);
    test_basic();
    test_crc_err();
    test_overflow();
    test_skip();
    test_len_zero_prefix();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cmd_decoder.md
CMD_DECODER -- requirements
Module: cmd_decoder

Interface
REQ-001 Parameters SHALL be: TIMEOUT_CYCLES, default 1000000, idle clocks inside a frame before abort; NUM_SOURCES, PREFIX and ADDR_AST taken from the shared defines.
REQ-002 Port: clk  in  1  single clock; all logic on rising edge.
REQ-003 Port: n_rst  in  1  reset, synchronous, active-low.
REQ-004 Port: rx_data  in  8  received byte, qualified by rx_valid.
REQ-005 Port: rx_valid  in  1  one-cycle strobe per byte; never back-pressured.
REQ-006 Port: full_bus  in  NUM_SOURCES  per-destination sink full flag.
REQ-007 Port: wrreq_bus  out  NUM_SOURCES  one-hot write strobe to destination sink.
REQ-008 Port: data_out  out  8  payload byte shared by all sinks, valid with wrreq_bus.
REQ-009 Port: frame_done  out  1  one-cycle pulse after a CRC byte of an accepted frame.
REQ-010 Port: dest_out  out  clog2(NUM_SOURCES)  destination of current/last frame.
REQ-011 Port: crc_err, ovf_err, timeout_err  out  1 each  one-cycle error pulses.
REQ-012 Port: my_state  out  3  debug copy of state register.

Function
REQ-013 Frame format SHALL be: PREFIX, ADDR_AST, dest, len, len payload bytes, crc; crc = sum of payload bytes mod 256 (0 when len = 0).
REQ-014 States SHALL be IDLE, GET_ADDR, GET_DEST, GET_LEN, GET_DATA, GET_CRC, SKIP_DATA, SKIP_CRC; transitions only on rx_valid except timeout.
REQ-015 IDLE: byte == PREFIX -> GET_ADDR; any other byte ignored.
REQ-016 GET_ADDR: byte == ADDR_AST -> GET_DEST; otherwise -> IDLE.
REQ-017 GET_DEST: latch dest; -> GET_LEN; dest >= NUM_SOURCES sets a skip flag.
REQ-018 GET_LEN: latch len, clear count and crc accumulator; len == 0 -> GET_CRC (or SKIP_CRC if skip flag); else GET_DATA (or SKIP_DATA).
REQ-019 GET_DATA: each byte adds to 8-bit accumulator (wraps), increments count; after byte number len -> GET_CRC.
REQ-020 Payload byte SHALL appear on data_out with wrreq_bus[dest] high exactly one clock after its rx_valid; wrreq_bus otherwise all zero.
REQ-021 If full_bus[dest] is high when a payload byte arrives, no write SHALL occur, the byte still counts in the CRC, and ovf_err pulses one clock later.
REQ-022 GET_CRC: next byte compared to accumulator; one clock later frame_done pulses, crc_err pulses with it on mismatch; -> IDLE.
REQ-023 SKIP_DATA/SKIP_CRC: consume len bytes then one CRC byte with no writes and no frame_done; -> IDLE.
REQ-024 An idle counter SHALL clear on every rx_valid and count otherwise; reaching TIMEOUT_CYCLES-1 in any state other than IDLE SHALL return to IDLE and pulse timeout_err; rx_valid in that same cycle takes priority (no timeout).
REQ-025 A PREFIX value inside the payload SHALL be treated as data (no resynchronisation).

Reset
REQ-026 n_rst low at a clock edge SHALL set state IDLE, wrreq_bus 0, data_out 0, dest_out 0, frame_done 0, all error pulses 0, counters and accumulator 0, mid-frame included; a frame cut by reset is never completed.

Structure
REQ-027 NUM_SOURCES, PREFIX, ADDR_AST and state encodings SHALL live in the shared defines file, common with the command encoder.
REQ-028 Single module, no sub-modules; the timeout counter is inline.

Verification
REQ-029 PREFIX, ADDR_AST, 1, 3, 0x10 0x20 0x30, 0x60 -> three wrreq_bus = 0b0010 strobes with data 0x10/0x20/0x30, frame_done, no crc_err.
REQ-030 Same frame with crc byte 0x61 -> three writes, frame_done plus crc_err in the same cycle.
REQ-031 Frame to dest 0 with len 2, full_bus[0] high during the 2nd byte -> one write, one ovf_err, frame_done, no crc_err.
REQ-032 Frame with dest = NUM_SOURCES, len 4 -> no writes, no frame_done; immediately following valid frame decoded correctly.
REQ-033 Frame stopped after 1 of 4 payload bytes, TIMEOUT_CYCLES = 16 -> timeout_err after 16 idle clocks, state IDLE; next frame decoded.
REQ-034 n_rst low for one clock after len byte -> all outputs 0, state IDLE, remaining payload bytes produce no writes.
